// File: rtl/stream_cmd_parser.sv
// Host byte-stream command parser: framed reg write/read, payload to FIFO, start/stop.
// Optional inter-byte timeout when STREAM_TIMEOUT_EN is defined.
module stream_cmd_parser #(
   parameter int         NUM_PARAMS   = 4,
   parameter int         PARAM_W      = 16,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 1200000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [7:0]                    fifo_wr_data,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   output logic [NUM_PARAMS*PARAM_W-1:0] cfg_param,
   output logic [1:0]                    cfg_mode,
   output logic                          mod_enable,
   output logic [7:0]                    err_count,
   output logic                          busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_OPC, S_ADDR, S_DHI, S_DLO, S_LHI,
      S_LLO, S_PAYLOAD, S_RESP_HI, S_RESP_LO, S_ACK
   } state_t;

   localparam logic [7:0] ACK_OK  = 8'h5A;
   localparam logic [7:0] ACK_ERR = 8'hEE;
   localparam logic [7:0] CTRL_A  = 8'(NUM_PARAMS);
   localparam logic [7:0] STAT_A  = 8'(NUM_PARAMS + 1);

   state_t state, state_nx;
   logic [7:0]  addr_q, dhi_q, ack_q, err_q, ack_nx;
   logic [15:0] cnt_q, resp_q, rd_word;
   logic        is_rd_q, mode_en_q, err_inc, ack_ld, wr_go, acc;
   logic [1:0]  mode_q;
   logic [NUM_PARAMS*PARAM_W-1:0] param_q;

   assign acc          = rx_valid & rx_ready;
   assign fifo_wr_data = rx_data;
   assign cfg_param    = param_q;
   assign cfg_mode     = mode_q;
   assign mod_enable   = mode_en_q;
   assign err_count    = err_q;
   assign busy         = (state != S_IDLE);

`ifdef STREAM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   logic [TW-1:0] tmo_q;
   logic          rx_wait, tmo_hit;

   assign rx_wait = (state >= S_OPC) && (state <= S_PAYLOAD) && !rx_valid
                    && !(state == S_PAYLOAD && fifo_full);
   assign tmo_hit = rx_wait && (tmo_q == TW'(TIMEOUT_CLKS - 1));

   // Inter-byte silence counter; FIFO back-pressure stalls it
   always_ff @(posedge clk) begin
      if (rst || state == S_IDLE || acc) tmo_q <= '0;
      else if (rx_wait)                  tmo_q <= tmo_q + 1'b1;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^32'(TIMEOUT_CLKS);
`endif

   // Read-back word for the address currently on rx_data
   always_comb begin
      rd_word = '0;
      for (int n = 0; n < NUM_PARAMS; n++)
         if (rx_data == 8'(n))
            rd_word = 16'(param_q[n*PARAM_W +: PARAM_W]);
      if (rx_data == CTRL_A) rd_word = {13'b0, mode_q, mode_en_q};
      if (rx_data == STAT_A) rd_word = {err_q, 7'b0, fifo_full};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next state, handshakes and per-frame side effects
   always_comb begin
      state_nx   = state;
      rx_ready   = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      fifo_wr_en = 1'b0;
      err_inc    = 1'b0;
      ack_ld     = 1'b0;
      ack_nx     = ACK_OK;
      wr_go      = 1'b0;
      if (!rst) begin
         unique case (state)
            S_IDLE: begin
               rx_ready = 1'b1;
               if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_OPC;
            end
            S_OPC: begin
               rx_ready = 1'b1;
               if (rx_valid) begin
                  ack_ld = 1'b1;
                  case (rx_data)
                     8'h01, 8'h02: state_nx = S_ADDR;
                     8'h03:        state_nx = S_LHI;
                     8'h04, 8'h05: state_nx = S_ACK;
                     default: begin
                        err_inc  = 1'b1;
                        ack_nx   = ACK_ERR;
                        state_nx = S_ACK;
                     end
                  endcase
               end
            end
            S_ADDR: begin
               rx_ready = 1'b1;
               if (rx_valid) begin
                  if (!is_rd_q) state_nx = S_DHI;
                  else if (rx_data <= STAT_A) state_nx = S_RESP_HI;
                  else begin
                     err_inc  = 1'b1;
                     ack_ld   = 1'b1;
                     ack_nx   = ACK_ERR;
                     state_nx = S_ACK;
                  end
               end
            end
            S_DHI: begin
               rx_ready = 1'b1;
               if (rx_valid) state_nx = S_DLO;
            end
            S_DLO: begin
               rx_ready = 1'b1;
               if (rx_valid) begin
                  state_nx = S_ACK;
                  if (addr_q <= CTRL_A) wr_go = 1'b1;
                  else begin
                     err_inc = 1'b1;
                     ack_ld  = 1'b1;
                     ack_nx  = ACK_ERR;
                  end
               end
            end
            S_LHI: begin
               rx_ready = 1'b1;
               if (rx_valid) state_nx = S_LLO;
            end
            S_LLO: begin
               rx_ready = 1'b1;
               if (rx_valid)
                  state_nx = ({cnt_q[15:8], rx_data} == 16'd0) ? S_ACK : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               rx_ready   = ~fifo_full;
               fifo_wr_en = rx_valid & ~fifo_full;
               if (fifo_wr_en && cnt_q == 16'd1) state_nx = S_ACK;
            end
            S_RESP_HI: begin
               tx_valid = 1'b1;
               tx_data  = resp_q[15:8];
               if (tx_ready) state_nx = S_RESP_LO;
            end
            S_RESP_LO: begin
               tx_valid = 1'b1;
               tx_data  = resp_q[7:0];
               if (tx_ready) state_nx = S_ACK;
            end
            S_ACK: begin
               tx_valid = 1'b1;
               tx_data  = ack_q;
               if (tx_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
`ifdef STREAM_TIMEOUT_EN
         if (tmo_hit) begin
            state_nx = S_IDLE;
            err_inc  = 1'b1;
         end
`endif
      end
   end

   // Frame fields, config registers and error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         dhi_q     <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         cnt_q     <= '0;
         resp_q    <= '0;
         is_rd_q   <= 1'b0;
         mode_en_q <= 1'b0;
         mode_q    <= '0;
         param_q   <= '0;
      end else begin
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
         if (ack_ld) ack_q <= ack_nx;
         if (acc) begin
            case (state)
               S_OPC: begin
                  is_rd_q <= (rx_data == 8'h02);
                  if (rx_data == 8'h04) mode_en_q <= 1'b1;
                  if (rx_data == 8'h05) mode_en_q <= 1'b0;
               end
               S_ADDR: begin
                  addr_q <= rx_data;
                  resp_q <= rd_word;
               end
               S_DHI: dhi_q <= rx_data;
               S_DLO: begin
                  if (wr_go && addr_q == CTRL_A) begin
                     mode_q    <= rx_data[2:1];
                     mode_en_q <= rx_data[0];
                  end
                  for (int n = 0; n < NUM_PARAMS; n++)
                     if (wr_go && addr_q == 8'(n))
                        param_q[n*PARAM_W +: PARAM_W] <= PARAM_W'({dhi_q, rx_data});
               end
               S_LHI:     cnt_q[15:8] <= rx_data;
               S_LLO:     cnt_q[7:0]  <= rx_data;
               S_PAYLOAD: cnt_q       <= cnt_q - 16'd1;
               default: ;
            endcase
         end
      end
   end

endmodule
